// File: rtl/margin_table_builder.sv
// Accumulates packed genotype/phenotype sample beats into a 2x3 saturating contingency table per record.
// Two-stage pipeline (per-beat cell counts, then accumulate); table is held until the downstream stage takes it.
module margin_table_builder #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*LANES-1:0]      geno_in,
    input  logic [LANES-1:0]        pheno_in,
    input  logic [LANES-1:0]        lane_mask_in,
    input  logic                    sample_valid_in,
    input  logic                    sample_last_in,
    output logic                    ready_out,
    output logic [6*DATA_WIDTH-1:0] margin_table_out,
    output logic                    overflow_out,
    output logic                    data_valid_out,
    input  logic                    table_ready_in
);
    localparam int CW = $clog2(LANES + 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, PRESENT} state_t;

    state_t                  state_q;
    logic                    ready_q;
    logic                    dv_q;
    logic                    ovf_q;
    logic [6*DATA_WIDTH-1:0] table_q;

    logic [CW-1:0]           cnt_d [6];
    logic [CW-1:0]           cnt_q [6];
    logic                    s1_vld_q;
    logic                    s1_last_q;

    logic [DATA_WIDTH-1:0]   acc_q [6];
    logic                    sticky_q;
    logic [DATA_WIDTH:0]     sum_w [6];
    logic [DATA_WIDTH-1:0]   sum_sat [6];
    logic [5:0]              sat;
    logic                    accept;

    assign accept           = sample_valid_in && ready_q;
    assign ready_out        = ready_q;
    assign data_valid_out   = dv_q;
    assign overflow_out     = ovf_q;
    assign margin_table_out = table_q;

    // Missing genotypes (code 3) and masked lanes contribute nothing.
    always_comb begin
        logic [2:0] idx;
        for (int c = 0; c < 6; c++) cnt_d[c] = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = {1'b0, geno_in[2*k +: 2]} + (pheno_in[k] ? 3'd3 : 3'd0);
            if (lane_mask_in[k] && geno_in[2*k +: 2] != 2'd3) begin
                for (int c = 0; c < 6; c++) begin
                    if (idx == 3'(c)) cnt_d[c] = cnt_d[c] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 6; c++) begin
            sum_w[c]   = {1'b0, acc_q[c]} + (DATA_WIDTH+1)'(cnt_q[c]);
            sat[c]     = sum_w[c][DATA_WIDTH];
            sum_sat[c] = sat[c] ? {DATA_WIDTH{1'b1}} : sum_w[c][DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            ready_q   <= 1'b1;
            dv_q      <= 1'b0;
            ovf_q     <= 1'b0;
            table_q   <= '0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            sticky_q  <= 1'b0;
            for (int c = 0; c < 6; c++) begin
                cnt_q[c] <= '0;
                acc_q[c] <= '0;
            end
        end else begin
            s1_vld_q  <= accept;
            s1_last_q <= accept && sample_last_in;
            for (int c = 0; c < 6; c++) cnt_q[c] <= accept ? cnt_d[c] : '0;

            if (s1_vld_q) begin
                if (s1_last_q) begin
                    for (int c = 0; c < 6; c++) begin
                        table_q[c*DATA_WIDTH +: DATA_WIDTH] <= sum_sat[c];
                        acc_q[c] <= '0;
                    end
                    ovf_q    <= sticky_q | (|sat);
                    sticky_q <= 1'b0;
                end else begin
                    for (int c = 0; c < 6; c++) acc_q[c] <= sum_sat[c];
                    sticky_q <= sticky_q | (|sat);
                end
            end

            case (state_q)
                ACCUM: begin
                    if (accept && sample_last_in) begin
                        state_q <= DRAIN;
                        ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (s1_vld_q && s1_last_q) begin
                        state_q <= PRESENT;
                        dv_q    <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (table_ready_in) begin
                        state_q <= ACCUM;
                        dv_q    <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                    ready_q <= 1'b1;
                    dv_q    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_margin_table_builder.sv
// Directed bench for margin_table_builder: 16-bit and 4-bit instances share one stimulus stream.
module tb_margin_table_builder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] geno_in;
    logic [7:0]  pheno_in;
    logic [7:0]  lane_mask_in;
    logic        sample_valid_in;
    logic        sample_last_in;
    logic        table_ready_in;

    logic        ready_out, overflow_out, data_valid_out;
    logic [95:0] margin_table_out;
    logic        ready4, overflow4, dv4;
    logic [23:0] table4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    margin_table_builder #(.DATA_WIDTH(16), .LANES(8)) dut (
        .clk(clk), .rst(rst), .geno_in(geno_in), .pheno_in(pheno_in),
        .lane_mask_in(lane_mask_in), .sample_valid_in(sample_valid_in),
        .sample_last_in(sample_last_in), .ready_out(ready_out),
        .margin_table_out(margin_table_out), .overflow_out(overflow_out),
        .data_valid_out(data_valid_out), .table_ready_in(table_ready_in)
    );

    margin_table_builder #(.DATA_WIDTH(4), .LANES(8)) dut4 (
        .clk(clk), .rst(rst), .geno_in(geno_in), .pheno_in(pheno_in),
        .lane_mask_in(lane_mask_in), .sample_valid_in(sample_valid_in),
        .sample_last_in(sample_last_in), .ready_out(ready4),
        .margin_table_out(table4), .overflow_out(overflow4),
        .data_valid_out(dv4), .table_ready_in(table_ready_in)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] tbl(input int e0, e1, e2, e3, e4, e5);
        return {16'(e5), 16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] g, input logic [7:0] p, input logic [7:0] m, input logic last);
        geno_in = g; pheno_in = p; lane_mask_in = m;
        sample_valid_in = 1'b1; sample_last_in = last;
        step();
        sample_valid_in = 1'b0; sample_last_in = 1'b0;
    endtask

    // Called in cycle t+1 after the last beat was accepted; table_ready_in assumed high.
    task automatic finish_record(input string tag, input logic [95:0] exp_tbl, input logic exp_ovf);
        check({tag, "_rdy_t1"}, 128'(ready_out), 128'(0));
        check({tag, "_dv_t1"}, 128'(data_valid_out), 128'(0));
        step();
        check({tag, "_dv_t2"}, 128'(data_valid_out), 128'(1));
        check({tag, "_rdy_t2"}, 128'(ready_out), 128'(0));
        check({tag, "_tbl"}, 128'(margin_table_out), 128'(exp_tbl));
        check({tag, "_ovf"}, 128'(overflow_out), 128'(exp_ovf));
        step();
        check({tag, "_dv_t3"}, 128'(data_valid_out), 128'(0));
        check({tag, "_rdy_t3"}, 128'(ready_out), 128'(1));
    endtask

    initial begin
        logic [95:0] held_tbl;
        int          rdy_low;
        logic        stable;

        rst = 1'b1; geno_in = '0; pheno_in = '0; lane_mask_in = '0;
        sample_valid_in = 1'b0; sample_last_in = 1'b0; table_ready_in = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_rdy", 128'(ready_out), 128'(1));
        check("rst_dv", 128'(data_valid_out), 128'(0));
        check("rst_ovf", 128'(overflow_out), 128'(0));
        check("rst_tbl", 128'(margin_table_out), 128'(0));

        // Single mixed beat: geno lanes 0..7 = 0,1,2,0,1,2,3,0; pheno = 0,0,0,1,1,1,1,0
        check("t1_rdy_t0", 128'(ready_out), 128'(1));
        send(16'h3924, 8'h78, 8'hFF, 1'b1);
        finish_record("t1", tbl(2, 1, 1, 1, 1, 1), 1'b0);

        // 100 back-to-back beats, 4 lanes of geno=1 pheno=1 each
        rdy_low = 0;
        for (int i = 0; i < 100; i++) begin
            if (!ready_out) rdy_low++;
            send(16'h5555, 8'hFF, 8'h0F, i == 99);
        end
        check("t2_rdy_during", 128'(rdy_low), 128'(0));
        finish_record("t2", tbl(0, 0, 0, 0, 400, 0), 1'b0);

        // Downstream stalls 10 cycles; beats offered meanwhile must be dropped
        table_ready_in = 1'b0;
        send(16'h3924, 8'h78, 8'hFF, 1'b1);
        step();
        check("t3_dv", 128'(data_valid_out), 128'(1));
        held_tbl = margin_table_out;
        check("t3_tbl", 128'(held_tbl), 128'(tbl(2, 1, 1, 1, 1, 1)));
        stable = 1'b1;
        geno_in = 16'h0000; pheno_in = 8'h00; lane_mask_in = 8'hFF;
        sample_valid_in = 1'b1; sample_last_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!data_valid_out || ready_out || margin_table_out !== held_tbl) stable = 1'b0;
        end
        check("t3_stable", 128'(stable), 128'(1));
        sample_valid_in = 1'b0; sample_last_in = 1'b0;
        table_ready_in = 1'b1;
        step();
        check("t3_dv_drop", 128'(data_valid_out), 128'(0));
        check("t3_tbl_hold", 128'(margin_table_out), 128'(held_tbl));
        check("t3_rdy_back", 128'(ready_out), 128'(1));
        send(16'h0000, 8'h00, 8'h01, 1'b1);
        finish_record("t3n", tbl(1, 0, 0, 0, 0, 0), 1'b0);

        // Saturation: 24 samples into cell 0 of the 4-bit instance
        for (int i = 0; i < 3; i++) send(16'h0000, 8'h00, 8'hFF, i == 2);
        step();
        check("t4_dv4", 128'(dv4), 128'(1));
        check("t4_sat_e0", 128'(table4[3:0]), 128'(15));
        check("t4_sat_rest", 128'(table4[23:4]), 128'(0));
        check("t4_ovf4", 128'(overflow4), 128'(1));
        check("t4_wide_e0", 128'(margin_table_out), 128'(tbl(24, 0, 0, 0, 0, 0)));
        check("t4_wide_ovf", 128'(overflow_out), 128'(0));
        step();
        send(16'h0000, 8'h00, 8'h01, 1'b1);
        step();
        check("t4n_tbl4", 128'(table4), 128'(24'h000001));
        check("t4n_ovf4", 128'(overflow4), 128'(0));
        step();

        // Empty records: no lanes, then all lanes missing
        send(16'h5555, 8'hAA, 8'h00, 1'b1);
        finish_record("t5", tbl(0, 0, 0, 0, 0, 0), 1'b0);
        send(16'hFFFF, 8'h0F, 8'hFF, 1'b1);
        finish_record("t5m", tbl(0, 0, 0, 0, 0, 0), 1'b0);

        // Reset mid-record after 5 beats
        for (int i = 0; i < 5; i++) send(16'h5555, 8'hFF, 8'hFF, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_tbl_rst", 128'(margin_table_out), 128'(0));
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (data_valid_out || !ready_out) stable = 1'b0;
            step();
        end
        check("t6_no_table", 128'(stable), 128'(1));
        // lane0 geno=2 pheno=0, lane1 geno=1 pheno=1
        send(16'h0006, 8'h02, 8'h03, 1'b1);
        finish_record("t6", tbl(0, 0, 1, 0, 1, 0), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
